mult_arbiter: RTL and testbench

MULT_ARBITER -- requirements
Module: mult_arbiter

---
 rtl/mult_arb_pkg.sv | 25 ++
 rtl/mult_arbiter_rr.sv | 33 +++
 rtl/mult_arbiter.sv | 172 +++++++++++++++++
 tb/tb_mult_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_arb_pkg.sv
// Shared types and sizing helpers for the multiplier arbiter and its round-robin picker.
package mult_arb_pkg;

    localparam int DEF_NREQ    = 4;
    localparam int DEF_WIDTH   = 16;
    localparam int DEF_TIMEOUT = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_CAPTURE,
        ST_RESP
    } arb_state_e;

    // Timeout counter width; kept at least one bit so TIMEOUT = 1 still elaborates.
    function automatic int cnt_width(input int timeout);
        return (timeout > 1) ? $clog2(timeout) : 1;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mult_arbiter_rr.sv
// Combinational round-robin pick: first valid requester after last_grant, wrapping modulo NREQ.
module rr_arbiter
    import mult_arb_pkg::*;
#(
    parameter  int NREQ = DEF_NREQ,
    localparam int IW   = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_grant,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_idx,
    output logic            grant_any
);

    logic [IW-1:0] cand_idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand_idx  = '0;
        // Offsets 1..NREQ visit last_grant itself last, so it only wins when alone.
        for (int off = 1; off <= NREQ; off++) begin
            cand_idx = IW'((int'(last_grant) + off) % NREQ);
            if (!grant_any && req[cand_idx]) begin
                grant_any       = 1'b1;
                grant_idx       = cand_idx;
                grant[cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one external sticky-done multiplier among NREQ requesters with round-robin grants
// and a bounded wait that reports a timeout as an error response.
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int NREQ    = DEF_NREQ,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic [NREQ-1:0]       rsp_valid,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic [2*WIDTH-1:0]    rsp_product,
    output logic                  rsp_err,
    output logic                  mul_start,
    output logic                  mul_flush,
    output logic [WIDTH-1:0]      mul_a,
    output logic [WIDTH-1:0]      mul_b,
    input  logic                  mul_done,
    input  logic [2*WIDTH-1:0]    mul_product,
    output logic                  busy
);

    localparam int IW = idx_width(NREQ);
    localparam int CW = cnt_width(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    arb_state_e         state_q, state_d;
    logic [IW-1:0]      grant_idx_q, grant_idx_d;
    logic [IW-1:0]      last_grant_q, last_grant_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               err_q, err_d;
    logic [WIDTH-1:0]   mul_a_q, mul_a_d;
    logic [WIDTH-1:0]   mul_b_q, mul_b_d;
    logic [2*WIDTH-1:0] rsp_product_q, rsp_product_d;

    logic [WIDTH-1:0]   a_arr [NREQ];
    logic [WIDTH-1:0]   b_arr [NREQ];
    logic [NREQ-1:0]    arb_grant;
    logic [IW-1:0]      arb_idx;
    logic               arb_any;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign a_arr[gi] = req_a[gi*WIDTH +: WIDTH];
            assign b_arr[gi] = req_b[gi*WIDTH +: WIDTH];
        end
    endgenerate

    rr_arbiter #(
        .NREQ(NREQ)
    ) u_rr (
        .req       (req_valid),
        .last_grant(last_grant_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .grant_any (arb_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (arb_any) state_d = ST_ISSUE;
            ST_ISSUE:   state_d = ST_WAIT;
            ST_WAIT:    if (mul_done || cnt_q == CNT_LAST) state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_RESP;
            ST_RESP:    if (rsp_ready[grant_idx_q]) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        grant_idx_d   = grant_idx_q;
        last_grant_d  = last_grant_q;
        cnt_d         = cnt_q;
        err_d         = err_q;
        mul_a_d       = mul_a_q;
        mul_b_d       = mul_b_q;
        rsp_product_d = rsp_product_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    grant_idx_d = arb_idx;
                    mul_a_d     = a_arr[arb_idx];
                    mul_b_d     = b_arr[arb_idx];
                end
            end
            ST_ISSUE: begin
                cnt_d = '0;
                err_d = 1'b0;
            end
            ST_WAIT: begin
                if (!mul_done) begin
                    if (cnt_q == CNT_LAST) begin
                        err_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            ST_CAPTURE: rsp_product_d = err_q ? '0 : mul_product;
            ST_RESP: begin
                if (rsp_ready[grant_idx_q]) begin
                    last_grant_d = grant_idx_q;
                    err_d        = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_idx_q   <= '0;
            last_grant_q  <= IW'(NREQ - 1);
            cnt_q         <= '0;
            err_q         <= 1'b0;
            mul_a_q       <= '0;
            mul_b_q       <= '0;
            rsp_product_q <= '0;
        end else begin
            grant_idx_q   <= grant_idx_d;
            last_grant_q  <= last_grant_d;
            cnt_q         <= cnt_d;
            err_q         <= err_d;
            mul_a_q       <= mul_a_d;
            mul_b_q       <= mul_b_d;
            rsp_product_q <= rsp_product_d;
        end
    end

    // Handshake outputs are decoded from state only, so reset forces them all low.
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        mul_start = 1'b0;
        mul_flush = 1'b0;
        rsp_err   = 1'b0;
        case (state_q)
            ST_ISSUE: begin
                req_ready[grant_idx_q] = 1'b1;
                mul_start              = 1'b1;
            end
            ST_CAPTURE: mul_flush = 1'b1;
            ST_RESP: begin
                rsp_valid[grant_idx_q] = 1'b1;
                rsp_err                = err_q;
            end
            default: ;
        endcase
    end

    assign busy        = (state_q != ST_IDLE);
    assign mul_a       = mul_a_q;
    assign mul_b       = mul_b_q;
    assign rsp_product = rsp_product_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter with a behavioural sticky-done multiplier of fixed latency.
module tb_mult_arbiter;

    localparam int NREQ    = 4;
    localparam int WIDTH   = 16;
    localparam int TIMEOUT = 64;
    localparam int LAT     = 4;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       rsp_valid;
    logic [NREQ-1:0]       rsp_ready = '0;
    logic [2*WIDTH-1:0]    rsp_product;
    logic                  rsp_err;
    logic                  mul_start;
    logic                  mul_flush;
    logic [WIDTH-1:0]      mul_a;
    logic [WIDTH-1:0]      mul_b;
    logic                  mul_done;
    logic [2*WIDTH-1:0]    mul_product;
    logic                  busy;

    logic [WIDTH-1:0] op_a [NREQ];
    logic [WIDTH-1:0] op_b [NREQ];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_pack
            assign req_a[gi*WIDTH +: WIDTH] = op_a[gi];
            assign req_b[gi*WIDTH +: WIDTH] = op_b[gi];
        end
    endgenerate

    mult_arbiter #(
        .NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_product(rsp_product), .rsp_err(rsp_err),
        .mul_start(mul_start), .mul_flush(mul_flush), .mul_a(mul_a), .mul_b(mul_b),
        .mul_done(mul_done), .mul_product(mul_product), .busy(busy)
    );

    // External multiplier stand-in: done rises LAT cycles after start and stays high until flush.
    logic              mul_hang = 1'b0;
    logic              mdl_busy;
    int                mdl_cnt;
    logic signed [31:0] ext_a, ext_b;
    assign ext_a = {{16{mul_a[15]}}, mul_a};
    assign ext_b = {{16{mul_b[15]}}, mul_b};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl_busy    <= 1'b0;
            mdl_cnt     <= 0;
            mul_done    <= 1'b0;
            mul_product <= '0;
        end else if (mul_flush) begin
            mdl_busy <= 1'b0;
            mul_done <= 1'b0;
        end else if (mul_start) begin
            mdl_busy    <= 1'b1;
            mdl_cnt     <= 0;
            mul_product <= ext_a * ext_b;
        end else if (mdl_busy && !mul_hang) begin
            if (mdl_cnt == LAT - 1) begin
                mul_done <= 1'b1;
                mdl_busy <= 1'b0;
            end else begin
                mdl_cnt <= mdl_cnt + 1;
            end
        end
    end

    int grant_log[$];
    int flush_cnt = 0;
    int overlap_cnt = 0;
    int multihot_cnt = 0;

    always @(negedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) grant_log.push_back(i);
        end
        if (mul_flush) flush_cnt++;
        if (mul_start && mul_flush) overlap_cnt++;
        if ($countones(req_ready) > 1 || $countones(rsp_valid) > 1) multihot_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
        $display("vec %0d %s obs=0x%0h exp=0x%0h", vectors, tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input logic [NREQ-1:0] exp, input string tag);
        int n;
        n = 0;
        while (req_ready == '0 && n < 50) begin
            tick();
            n++;
        end
        chk(tag, req_ready, exp);
    endtask

    // Waits for the response, checks it, then accepts it with the granted rsp_ready bit.
    task automatic finish_op(input int idx, input logic [31:0] exp_prod, input logic exp_err,
                             input string tag);
        int n;
        logic [NREQ-1:0] oh;
        oh = '0;
        oh[idx] = 1'b1;
        n = 0;
        while (rsp_valid == '0 && n < 200) begin
            tick();
            n++;
        end
        chk({tag, "_rsp_valid"}, rsp_valid, oh);
        chk({tag, "_product"}, rsp_product, exp_prod);
        chk({tag, "_err"}, rsp_err, exp_err);
        rsp_ready[idx] = 1'b1;
        tick();
        rsp_ready[idx] = 1'b0;
        chk({tag, "_idle"}, {busy, rsp_valid}, '0);
    endtask

    task automatic run_single(input int idx, input logic [15:0] a, input logic [15:0] b,
                              input logic [31:0] exp_prod, input string tag);
        logic [NREQ-1:0] oh;
        oh = '0;
        oh[idx] = 1'b1;
        op_a[idx] = a;
        op_b[idx] = b;
        req_valid[idx] = 1'b1;
        wait_ready(oh, {tag, "_req_ready"});
        req_valid[idx] = 1'b0;
        finish_op(idx, exp_prod, 1'b0, tag);
    endtask

    int rr_exp[6] = '{0, 1, 2, 3, 0, 1};
    int n;
    int flush_base;

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            op_a[i] = '0;
            op_b[i] = '0;
        end

        // Reset state
        repeat (3) tick();
        chk("rst_req_ready", req_ready, 4'h0);
        chk("rst_rsp_valid", rsp_valid, 4'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_strobes", {mul_start, mul_flush, rsp_err}, 3'b000);
        chk("rst_product", rsp_product, 32'h0);
        rst_n = 1'b1;
        tick();

        // Single requester and signed corner products
        run_single(1, 16'd3, 16'hFFFE, 32'hFFFF_FFFA, "r1_3x-2");
        run_single(2, 16'h8000, 16'h8000, 32'h4000_0000, "r2_minmin");
        run_single(3, 16'h7FFF, 16'h7FFF, 32'h3FFF_0001, "r3_maxmax");

        // All four requesting with rsp_ready tied high: strict rotation from requester 0
        for (int i = 0; i < NREQ; i++) begin
            op_a[i] = 16'(i + 1);
            op_b[i] = 16'd10;
        end
        grant_log.delete();
        rsp_ready = 4'hF;
        req_valid = 4'hF;
        n = 0;
        while (grant_log.size() < 6 && n < 400) begin
            tick();
            n++;
        end
        req_valid = 4'h0;
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        rsp_ready = 4'h0;
        chk("rr_count", grant_log.size(), 6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("rr_grant%0d", i), grant_log[i], rr_exp[i]);
        end

        // Response stall: non-granted rsp_ready ignored, nothing new granted meanwhile
        op_a[0] = 16'd100;
        op_b[0] = 16'hFFF9;
        op_a[1] = 16'd5;
        op_b[1] = 16'd6;
        req_valid = 4'b0011;
        wait_ready(4'b0001, "stall_grant0");
        req_valid[0] = 1'b0;
        n = 0;
        while (rsp_valid == '0 && n < 200) begin
            tick();
            n++;
        end
        rsp_ready = 4'b0010;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("stall%0d_state", i), {busy, req_ready, rsp_valid}, {1'b1, 4'b0000, 4'b0001});
            chk($sformatf("stall%0d_product", i), rsp_product, 32'hFFFF_FD44);
            tick();
        end
        rsp_ready = 4'b0001;
        tick();
        rsp_ready = 4'b0000;
        wait_ready(4'b0010, "stall_next_grant1");
        req_valid[1] = 1'b0;
        finish_op(1, 32'h0000_001E, 1'b0, "r1_5x6");

        // Timeout: ISSUE + 64 WAIT cycles + CAPTURE before the error response appears
        mul_hang = 1'b1;
        op_a[2] = 16'd1;
        op_b[2] = 16'd1;
        req_valid[2] = 1'b1;
        wait_ready(4'b0100, "to_grant2");
        chk("to_mul_start", mul_start, 1'b1);
        req_valid[2] = 1'b0;
        flush_base = flush_cnt;
        n = 0;
        while (rsp_valid == '0 && n < 200) begin
            tick();
            n++;
        end
        chk("to_latency", n, 66);
        chk("to_flush", flush_cnt - flush_base, 1);
        finish_op(2, 32'h0, 1'b1, "to");
        mul_hang = 1'b0;

        // Reset in WAIT aborts the operation and restarts priority at requester 0
        mul_hang = 1'b1;
        op_a[3] = 16'd9;
        op_b[3] = 16'd9;
        req_valid[3] = 1'b1;
        wait_ready(4'b1000, "rst_grant3");
        req_valid[3] = 1'b0;
        repeat (3) tick();
        chk("pre_rst_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("midrst_ctrl", {busy, req_ready, rsp_valid, mul_start, mul_flush, rsp_err}, '0);
        chk("midrst_mul_ab", {mul_a, mul_b}, 32'h0);
        tick();
        rst_n = 1'b1;
        mul_hang = 1'b0;
        op_a[0] = 16'hFFFB;
        op_b[0] = 16'd7;
        req_valid = 4'b1001;
        wait_ready(4'b0001, "postrst_grant0");
        req_valid[0] = 1'b0;
        finish_op(0, 32'hFFFF_FFDD, 1'b0, "postrst_r0");
        wait_ready(4'b1000, "postrst_grant3");
        req_valid[3] = 1'b0;
        finish_op(3, 32'h0000_0051, 1'b0, "postrst_r3");

        chk("no_start_flush_overlap", overlap_cnt, 0);
        chk("onehot_outputs", multihot_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
